// File: rtl/core_pkg.sv
// core_pkg: shared types for the RV32 core pipeline stages.
// Memory operation encoding and MEM-stage FSM states.
package core_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic      uns;
        mem_size_t size;
    } mem_op_t;

    typedef logic [0:0] mem_state_t;

    localparam mem_state_t IDLE     = 1'b0;
    localparam mem_state_t WAIT_RSP = 1'b1;

endpackage

// File: rtl/core_mem_align.sv
// core_mem_align: misalign detect, store lane steering and
// load lane extraction with sign/zero extension.
module core_mem_align
    import core_pkg::*;
(
    input  logic [1:0]  req_lane,
    input  mem_size_t   req_size,
    input  logic [31:0] req_data,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_lane,
    input  mem_op_t     ld_op,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ext;

    always_comb begin
        misaligned = 1'b0;
        wstrb      = 4'hF;
        wdata      = req_data;
        unique case (1'b1)
            req_size == MEM_B: begin
                wstrb = 4'b0001 << req_lane;
                wdata = {4{req_data[7:0]}};
            end
            req_size == MEM_H: begin
                misaligned = req_lane[0];
                wstrb      = 4'b0011 << req_lane;
                wdata      = {2{req_data[15:0]}};
            end
            default: misaligned = req_lane != 2'b00;
        endcase
    end

    assign ld_byte = rdata[{ld_lane, 3'b000} +: 8];
    assign ld_half = rdata[{ld_lane[1], 4'b0000} +: 16];
    assign ext     = !ld_op.uns;

    always_comb begin
        ld_data = rdata;
        unique case (1'b1)
            ld_op.size == MEM_B:
                ld_data = {{24{ext & ld_byte[7]}}, ld_byte};
            ld_op.size == MEM_H:
                ld_data = {{16{ext & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// core_mem: RV32 memory-access stage; drives the data bus and
// owns the MEM/WB register feeding writeback and EX bypass.
module core_mem
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rest,
    input  logic            em_valid,
    output logic            em_ready,
    input  logic [XLEN-1:0] em_reg_data_mem_addr,
    input  logic [XLEN-1:0] em_csr_data_mem_data,
    input  logic            em_mem_read,
    input  logic            em_mem_write,
    input  mem_op_t         em_mem_op,
    input  logic [4:0]      em_rd,
    input  logic            em_reg_write,
    input  logic [11:0]     em_csr,
    input  logic            em_csr_write,
    output logic            dbus_req_valid,
    input  logic            dbus_req_ready,
    output logic [XLEN-1:0] dbus_addr,
    output logic            dbus_we,
    output logic [3:0]      dbus_wstrb,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_rsp_valid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            mw_valid,
    input  logic            mw_ready,
    output logic [4:0]      mw_rd,
    output logic            mw_reg_write,
    output logic [XLEN-1:0] mw_reg_write_data,
    output logic            mw_mem_data_valid,
    output logic [11:0]     mw_csr,
    output logic            mw_csr_write,
    output logic [XLEN-1:0] mw_csr_data,
    output logic            misalign_valid,
    output logic [XLEN-1:0] misalign_addr,
    output logic            misalign_store
);

    mem_state_t      state;
    mem_op_t         ld_op;
    logic            mem_op;
    logic            op_misaligned;
    logic            misaligned;
    logic            mw_free;
    logic            take;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;

    // The pending load's lane is still in mw_reg_write_data[1:0].
    core_mem_align u_align (
        .req_lane  (em_reg_data_mem_addr[1:0]),
        .req_size  (em_mem_op.size),
        .req_data  (em_csr_data_mem_data),
        .misaligned(op_misaligned),
        .wstrb     (st_strb),
        .wdata     (st_data),
        .ld_lane   (mw_reg_write_data[1:0]),
        .ld_op     (ld_op),
        .rdata     (dbus_rdata),
        .ld_data   (ld_data)
    );

    assign mem_op     = em_mem_read || em_mem_write;
    assign misaligned = mem_op && op_misaligned;
    assign mw_free    = !mw_valid || (mw_ready && mw_mem_data_valid);
    assign take       = em_valid && em_ready;

    always_comb begin
        em_ready       = 1'b0;
        dbus_req_valid = 1'b0;
        if (rest && state == IDLE && em_valid && mw_free) begin
            if (mem_op && !misaligned) begin
                dbus_req_valid = 1'b1;
                em_ready       = dbus_req_ready;
            end else begin
                em_ready = 1'b1;
            end
        end
    end

    assign dbus_addr  = rest ? {em_reg_data_mem_addr[XLEN-1:2], 2'b00} : '0;
    assign dbus_we    = rest && em_mem_write;
    assign dbus_wstrb = (rest && em_mem_write) ? st_strb : 4'h0;
    assign dbus_wdata = rest ? st_data : '0;

    always_ff @(posedge clk) begin
        if (!rest) begin
            state             <= IDLE;
            ld_op             <= '0;
            mw_valid          <= 1'b0;
            mw_rd             <= '0;
            mw_reg_write      <= 1'b0;
            mw_reg_write_data <= '0;
            mw_mem_data_valid <= 1'b0;
            mw_csr            <= '0;
            mw_csr_write      <= 1'b0;
            mw_csr_data       <= '0;
            misalign_valid    <= 1'b0;
            misalign_addr     <= '0;
            misalign_store    <= 1'b0;
        end else begin
            misalign_valid <= 1'b0;
            if (take) begin
                mw_valid          <= 1'b1;
                mw_rd             <= em_rd;
                mw_reg_write      <= em_reg_write && !misaligned;
                mw_reg_write_data <= em_reg_data_mem_addr;
                mw_mem_data_valid <= !(em_mem_read && !misaligned);
                mw_csr            <= em_csr;
                mw_csr_write      <= em_csr_write;
                mw_csr_data       <= em_csr_data_mem_data;
                ld_op             <= em_mem_op;
                if (em_mem_read && !misaligned) begin
                    state <= WAIT_RSP;
                end
                if (misaligned) begin
                    misalign_valid <= 1'b1;
                    misalign_addr  <= em_reg_data_mem_addr;
                    misalign_store <= em_mem_write;
                end
            end else if (state == WAIT_RSP) begin
                if (dbus_rsp_valid) begin
                    mw_reg_write_data <= ld_data;
                    mw_mem_data_valid <= 1'b1;
                    state             <= IDLE;
                end
            end else if (mw_ready && mw_mem_data_valid) begin
                mw_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: directed scenarios plus randomized traffic checked
// against a transaction-level model of the MEM stage.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        rest;
    logic        em_valid;
    logic        em_ready;
    logic [31:0] em_reg_data_mem_addr;
    logic [31:0] em_csr_data_mem_data;
    logic        em_mem_read;
    logic        em_mem_write;
    logic [2:0]  em_mem_op;
    logic [4:0]  em_rd;
    logic        em_reg_write;
    logic [11:0] em_csr;
    logic        em_csr_write;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;
    logic        mw_valid;
    logic        mw_ready;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic [31:0] mw_reg_write_data;
    logic        mw_mem_data_valid;
    logic [11:0] mw_csr;
    logic        mw_csr_write;
    logic [31:0] mw_csr_data;
    logic        misalign_valid;
    logic [31:0] misalign_addr;
    logic        misalign_store;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic [11:0] csr;
        logic        cw;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic [11:0] csr;
        logic        cw;
        logic [31:0] csr_data;
    } wb_t;

    wb_t exp_q[$];

    always #5 clk = ~clk;

    core_mem dut (
        .clk                 (clk),
        .rest                (rest),
        .em_valid            (em_valid),
        .em_ready            (em_ready),
        .em_reg_data_mem_addr(em_reg_data_mem_addr),
        .em_csr_data_mem_data(em_csr_data_mem_data),
        .em_mem_read         (em_mem_read),
        .em_mem_write        (em_mem_write),
        .em_mem_op           (em_mem_op),
        .em_rd               (em_rd),
        .em_reg_write        (em_reg_write),
        .em_csr              (em_csr),
        .em_csr_write        (em_csr_write),
        .dbus_req_valid      (dbus_req_valid),
        .dbus_req_ready      (dbus_req_ready),
        .dbus_addr           (dbus_addr),
        .dbus_we             (dbus_we),
        .dbus_wstrb          (dbus_wstrb),
        .dbus_wdata          (dbus_wdata),
        .dbus_rsp_valid      (dbus_rsp_valid),
        .dbus_rdata          (dbus_rdata),
        .mw_valid            (mw_valid),
        .mw_ready            (mw_ready),
        .mw_rd               (mw_rd),
        .mw_reg_write        (mw_reg_write),
        .mw_reg_write_data   (mw_reg_write_data),
        .mw_mem_data_valid   (mw_mem_data_valid),
        .mw_csr              (mw_csr),
        .mw_csr_write        (mw_csr_write),
        .mw_csr_data         (mw_csr_data),
        .misalign_valid      (misalign_valid),
        .misalign_addr       (misalign_addr),
        .misalign_store      (misalign_store)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic em_set(input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic rd_en,
                          input logic wr_en, input logic [2:0] op,
                          input logic [4:0] rd, input logic rw);
        em_valid             = v;
        em_reg_data_mem_addr = a;
        em_csr_data_mem_data = d;
        em_mem_read          = rd_en;
        em_mem_write         = wr_en;
        em_mem_op            = op;
        em_rd                = rd;
        em_reg_write         = rw;
        em_csr               = 12'h000;
        em_csr_write         = 1'b0;
    endtask

    // Reference rules written as plain arithmetic on the word.
    function automatic logic [31:0] ref_load(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input logic [2:0] op);
        logic [31:0] v;
        int unsigned lane;
        lane = a % 4;
        v = w;
        if (op[1:0] == 2'b00) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!op[2] && v >= 128) v = v - 256;
        end else if (op[1:0] == 2'b01) begin
            v = (w >> (16 * (lane / 2))) & 32'hFFFF;
            if (!op[2] && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a,
                                            input logic [2:0] op);
        int unsigned n;
        n = 15;
        if (op[1:0] == 2'b00) n = 1 << (a % 4);
        if (op[1:0] == 2'b01) n = 3 << (a % 4);
        return 4'(n);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d,
                                              input logic [2:0] op);
        if (op[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (op[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic ref_mis(input instr_t t);
        if (!(t.rd_en || t.wr_en)) return 1'b0;
        if (t.op[1:0] == 2'b01) return (t.addr % 2) != 0;
        if (t.op[1:0] == 2'b10) return (t.addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic instr_t gen_instr();
        instr_t t;
        int k;
        t.addr  = $urandom;
        t.data  = $urandom;
        t.rd    = 5'($urandom);
        t.rw    = 1'($urandom);
        t.csr   = 12'($urandom);
        t.cw    = 1'($urandom);
        t.rdata = $urandom;
        t.op    = {1'($urandom), 2'($urandom_range(0, 2))};
        k       = $urandom_range(0, 3);
        t.rd_en = (k == 1);
        t.wr_en = (k == 2);
        if ((k == 1 || k == 2) && $urandom_range(0, 3) != 0) begin
            if (t.op[1:0] == 2'b01) t.addr[0] = 1'b0;
            if (t.op[1:0] == 2'b10) t.addr[1:0] = 2'b00;
        end
        return t;
    endfunction

    function automatic wb_t expect_wb(input instr_t t);
        wb_t e;
        logic mis;
        mis        = ref_mis(t);
        e.rd       = t.rd;
        e.rw       = mis ? 1'b0 : t.rw;
        e.data     = (t.rd_en && !mis) ? ref_load(t.rdata, t.addr, t.op)
                                       : t.addr;
        e.csr      = t.csr;
        e.cw       = t.cw;
        e.csr_data = t.data;
        return e;
    endfunction

    task automatic load_case(input logic [2:0] op, input logic [31:0] exp);
        em_set(1'b1, 32'h1003, 32'h0, 1'b1, 1'b0, op, 5'd6, 1'b1);
        dbus_req_ready = 1'b1;
        #1;
        chk1("lb_req_valid", dbus_req_valid, 1'b1);
        chk("lb_bus_addr", dbus_addr, 32'h1000);
        chk1("lb_em_ready", em_ready, 1'b1);
        cyc();
        em_valid       = 1'b0;
        dbus_req_ready = 1'b0;
        #1;
        chk1("lb_mdv_pending", mw_mem_data_valid, 1'b0);
        chk1("lb_mw_valid", mw_valid, 1'b1);
        cyc();
        dbus_rsp_valid = 1'b1;
        dbus_rdata     = 32'h80FF_FF00;
        #1;
        chk1("lb_mdv_pending2", mw_mem_data_valid, 1'b0);
        cyc();
        dbus_rsp_valid = 1'b0;
        #1;
        chk1("lb_mdv_done", mw_mem_data_valid, 1'b1);
        chk("lb_data", mw_reg_write_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t cur;
        wb_t    e;
        logic   have;
        logic   outstanding;
        int     cnt;
        logic [31:0] out_rdata;
        logic   exp_mis;
        logic [31:0] exp_mis_addr;
        logic   exp_mis_store;

        rest           = 1'b0;
        dbus_req_ready = 1'b1;
        dbus_rsp_valid = 1'b0;
        dbus_rdata     = 32'h0;
        mw_ready       = 1'b1;
        em_set(1'b1, 32'h1234, 32'h0, 1'b1, 1'b0, 3'b010, 5'd1, 1'b1);
        cyc();
        cyc();
        #1;
        chk1("rst_mw_valid", mw_valid, 1'b0);
        chk("rst_mw_data", mw_reg_write_data, 32'h0);
        chk1("rst_mdv", mw_mem_data_valid, 1'b0);
        chk1("rst_mis_valid", misalign_valid, 1'b0);
        chk1("rst_em_ready", em_ready, 1'b0);
        chk1("rst_req_valid", dbus_req_valid, 1'b0);
        chk("rst_dbus_addr", dbus_addr, 32'h0);

        cyc();
        rest = 1'b1;
        em_set(1'b1, 32'h1234, 32'hCAFE, 1'b0, 1'b0, 3'b010, 5'd5, 1'b1);
        em_csr       = 12'h300;
        em_csr_write = 1'b1;
        #1;
        chk1("alu_em_ready", em_ready, 1'b1);
        chk1("alu_no_req", dbus_req_valid, 1'b0);
        cyc();
        em_valid = 1'b0;
        #1;
        chk1("alu_mw_valid", mw_valid, 1'b1);
        chk("alu_data", mw_reg_write_data, 32'h1234);
        chk1("alu_mdv", mw_mem_data_valid, 1'b1);
        chk("alu_rd", 32'(mw_rd), 32'd5);
        chk("alu_csr", 32'(mw_csr), 32'h300);
        chk("alu_csr_data", mw_csr_data, 32'hCAFE);
        cyc();
        #1;
        chk1("alu_drained", mw_valid, 1'b0);

        load_case(3'b000, 32'hFFFF_FF80);
        load_case(3'b100, 32'h0000_0080);

        cyc();
        em_set(1'b1, 32'h2002, 32'hAAAA_BEEF, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0);
        dbus_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("sh_req_valid", dbus_req_valid, 1'b1);
            chk1("sh_em_ready_low", em_ready, 1'b0);
            chk("sh_addr", dbus_addr, 32'h2000);
            chk("sh_wstrb", 32'(dbus_wstrb), 32'hC);
            chk("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
            chk1("sh_we", dbus_we, 1'b1);
            cyc();
        end
        dbus_req_ready = 1'b1;
        #1;
        chk1("sh_em_ready_acc", em_ready, 1'b1);
        chk("sh_wstrb_acc", 32'(dbus_wstrb), 32'hC);
        cyc();
        em_valid       = 1'b0;
        dbus_req_ready = 1'b0;
        #1;
        chk1("sh_mw_valid", mw_valid, 1'b1);
        chk1("sh_mdv", mw_mem_data_valid, 1'b1);
        chk("sh_mw_data", mw_reg_write_data, 32'h2002);
        chk1("sh_req_after", dbus_req_valid, 1'b0);

        em_set(1'b1, 32'h3001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1);
        dbus_req_ready = 1'b1;
        #1;
        chk1("mis_no_req", dbus_req_valid, 1'b0);
        chk1("mis_em_ready", em_ready, 1'b1);
        cyc();
        em_valid = 1'b0;
        #1;
        chk1("mis_valid", misalign_valid, 1'b1);
        chk("mis_addr", misalign_addr, 32'h3001);
        chk1("mis_store", misalign_store, 1'b0);
        chk1("mis_rw", mw_reg_write, 1'b0);
        chk1("mis_mdv", mw_mem_data_valid, 1'b1);
        cyc();
        #1;
        chk1("mis_pulse_end", misalign_valid, 1'b0);

        cyc();
        mw_ready = 1'b0;
        em_set(1'b1, 32'h4000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        #1;
        chk1("b2b_lw_ready", em_ready, 1'b1);
        cyc();
        em_set(1'b1, 32'h55, 32'h0, 1'b0, 1'b0, 3'b010, 5'd4, 1'b1);
        dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b1;
        dbus_rdata     = 32'h1234_5678;
        #1;
        chk1("b2b_wait_ready", em_ready, 1'b0);
        cyc();
        dbus_rsp_valid = 1'b0;
        #1;
        chk1("b2b_stall1", em_ready, 1'b0);
        chk("b2b_lw_data", mw_reg_write_data, 32'h1234_5678);
        chk("b2b_lw_rd", 32'(mw_rd), 32'd3);
        cyc();
        #1;
        chk1("b2b_stall2", em_ready, 1'b0);
        chk("b2b_hold", mw_reg_write_data, 32'h1234_5678);
        cyc();
        mw_ready = 1'b1;
        #1;
        chk1("b2b_go", em_ready, 1'b1);
        cyc();
        em_valid = 1'b0;
        #1;
        chk1("b2b_add_valid", mw_valid, 1'b1);
        chk("b2b_add_rd", 32'(mw_rd), 32'd4);
        chk("b2b_add_data", mw_reg_write_data, 32'h55);

        em_set(1'b1, 32'h5000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1);
        dbus_req_ready = 1'b1;
        #1;
        chk1("rr_req", dbus_req_valid, 1'b1);
        cyc();
        em_valid       = 1'b0;
        dbus_req_ready = 1'b0;
        rest           = 1'b0;
        #1;
        chk1("rr_pending", mw_mem_data_valid, 1'b0);
        cyc();
        rest           = 1'b1;
        dbus_rsp_valid = 1'b1;
        dbus_rdata     = 32'hDEAD_BEEF;
        #1;
        chk1("rr_mw_valid", mw_valid, 1'b0);
        cyc();
        dbus_rsp_valid = 1'b0;
        #1;
        chk1("rr_mw_valid2", mw_valid, 1'b0);
        chk("rr_data", mw_reg_write_data, 32'h0);
        chk1("rr_mdv", mw_mem_data_valid, 1'b0);
        em_set(1'b1, 32'h77, 32'h0, 1'b0, 1'b0, 3'b010, 5'd2, 1'b1);
        #1;
        chk1("rr_idle_ready", em_ready, 1'b1);
        cyc();
        em_valid = 1'b0;
        #1;
        chk("rr_alu_data", mw_reg_write_data, 32'h77);
        cyc();

        have          = 1'b0;
        outstanding   = 1'b0;
        cnt           = 0;
        out_rdata     = 32'h0;
        exp_mis       = 1'b0;
        exp_mis_addr  = 32'h0;
        exp_mis_store = 1'b0;
        cur           = gen_instr();
        for (int c = 0; c < 900; c++) begin
            if (c >= 600 && !have && !outstanding && exp_q.size() == 0)
                break;
            cyc();
            dbus_rsp_valid = 1'b0;
            dbus_rdata     = $urandom;
            if (outstanding) begin
                if (cnt == 0) begin
                    dbus_rsp_valid = 1'b1;
                    dbus_rdata     = out_rdata;
                end else begin
                    cnt--;
                end
            end
            if (!have && c < 600 && $urandom_range(0, 2) != 0) begin
                cur  = gen_instr();
                have = 1'b1;
            end
            em_set(have, cur.addr, cur.data, cur.rd_en, cur.wr_en,
                   cur.op, cur.rd, cur.rw);
            em_csr         = cur.csr;
            em_csr_write   = cur.cw;
            dbus_req_ready = 1'($urandom_range(0, 1));
            mw_ready       = $urandom_range(0, 3) != 0;
            #1;
            chk1("rnd_mis_pulse", misalign_valid, exp_mis);
            if (exp_mis) begin
                chk("rnd_mis_addr", misalign_addr, exp_mis_addr);
                chk1("rnd_mis_store", misalign_store, exp_mis_store);
            end
            exp_mis = 1'b0;
            if (mw_valid && mw_ready && mw_mem_data_valid) begin
                chk1("rnd_wb_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rnd_wb_rd", 32'(mw_rd), 32'(e.rd));
                    chk1("rnd_wb_rw", mw_reg_write, e.rw);
                    chk("rnd_wb_data", mw_reg_write_data, e.data);
                    chk("rnd_wb_csr", 32'(mw_csr), 32'(e.csr));
                    chk1("rnd_wb_cw", mw_csr_write, e.cw);
                    chk("rnd_wb_csr_data", mw_csr_data, e.csr_data);
                end
            end
            if (outstanding) chk1("rnd_one_outstanding", em_ready, 1'b0);
            if (dbus_rsp_valid) outstanding = 1'b0;
            if (dbus_req_valid && dbus_req_ready) begin
                chk1("rnd_req_for_em", have, 1'b1);
                chk("rnd_req_addr", dbus_addr, cur.addr & 32'hFFFF_FFFC);
                chk1("rnd_req_we", dbus_we, cur.wr_en);
                if (cur.wr_en) begin
                    chk("rnd_req_wstrb", 32'(dbus_wstrb),
                        32'(ref_strb(cur.addr, cur.op)));
                    chk("rnd_req_wdata", dbus_wdata,
                        ref_wdata(cur.data, cur.op));
                end
                if (cur.rd_en) begin
                    outstanding = 1'b1;
                    cnt         = $urandom_range(0, 2);
                    out_rdata   = cur.rdata;
                end
            end
            if (em_valid && em_ready) begin
                exp_q.push_back(expect_wb(cur));
                if (ref_mis(cur)) begin
                    exp_mis       = 1'b1;
                    exp_mis_addr  = cur.addr;
                    exp_mis_store = cur.wr_en;
                end
                have = 1'b0;
            end
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk1("rnd_em_drained", have, 1'b0);
        chk1("rnd_no_outstanding", outstanding, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
